// File: rtl/mul4_sequencer.sv
// Two-requester 4x4 unsigned multiply sequencer over a shared 2x2 multiplier.
// Four partial products are accumulated in MUL, then published for one DONE cycle.
module mul4_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic       req1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [1:0] mul_a,
   output logic [1:0] mul_b,
   input  logic [3:0] mul_p,
   output logic       busy,
   output logic       done,
   output logic       id,
   output logic [7:0] product
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [1:0] step;
   logic [3:0] a_r;
   logic [3:0] b_r;
   logic [7:0] acc;
   logic [7:0] term;
   logic       cur_id;
   logic       last;
   logic       any_req;
   logic       win1;

   assign any_req = req0 | req1;
   // requester 1 wins alone, or on a tie when 0 was served last
   assign win1 = req1 & (~req0 | ~last);

   always_comb begin
      term = 8'd0;
      unique case (step)
         2'd0: term = {4'd0, mul_p};
         2'd1: term = {2'd0, mul_p, 2'd0};
         2'd2: term = {2'd0, mul_p, 2'd0};
         2'd3: term = {mul_p, 4'd0};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (any_req) state_nx = S_MUL;
         S_MUL:  if (step == 2'd3) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != S_IDLE);
      done  = (state == S_DONE);
      mul_a = 2'd0;
      mul_b = 2'd0;
      if (state == S_MUL) begin
         mul_a = step[1] ? a_r[3:2] : a_r[1:0];
         mul_b = step[0] ? b_r[3:2] : b_r[1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step    <= 2'd0;
         a_r     <= 4'd0;
         b_r     <= 4'd0;
         acc     <= 8'd0;
         cur_id  <= 1'b0;
         last    <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         product <= 8'd0;
         id      <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  a_r    <= win1 ? a1 : a0;
                  b_r    <= win1 ? b1 : b0;
                  cur_id <= win1;
                  last   <= win1;
                  acc    <= 8'd0;
                  step   <= 2'd0;
                  gnt0   <= ~win1;
                  gnt1   <= win1;
               end
            end
            S_MUL: begin
               acc  <= acc + term;
               step <= step + 2'd1;
               if (step == 2'd3) begin
                  product <= acc + term;
                  id      <= cur_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mul4_sequencer.md
MUL4_SEQUENCER -- requirements
Module: mul4_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 multiply request; held high until gnt0.
REQ-005 a0, b0  input  4 each  requester 0 operands; valid while req0 is high.
REQ-006 req1  input  1  requester 1 multiply request; held high until gnt1.
REQ-007 a1, b1  input  4 each  requester 1 operands; valid while req1 is high.
REQ-008 gnt0, gnt1  output  1 each  one-cycle acceptance pulse per requester.
REQ-009 mul_a, mul_b  output  2 each  operand pair driven to the shared combinational 2x2 multiplier.
REQ-010 mul_p  input  4  product returned by the shared 2x2 multiplier in the same cycle.
REQ-011 busy  output  1  high while an operation is in progress, MUL or DONE state.
REQ-012 done  output  1  one-cycle pulse; product and id are valid.
REQ-013 id  output  1  requester index of the completed operation.
REQ-014 product  output  8  unsigned 4x4 product of the completed operation.

Function
REQ-015 The FSM SHALL have states IDLE, MUL and DONE, with a 2-bit step counter used in MUL.
REQ-016 IDLE with any req high: at the clock edge, latch the winner's operands into A[3:0] and B[3:0], set id, clear the accumulator, step=0, go to MUL.
REQ-017 Arbitration SHALL occur only in IDLE.
REQ-018 A single request SHALL always win.
REQ-019 Simultaneous requests SHALL be resolved round-robin: the requester not served last wins; the last-served pointer updates on every acceptance.
REQ-020 gntN SHALL be registered and high for exactly the first MUL cycle after acceptance of requester N; gnt0 and gnt1 are never high together.
REQ-021 In MUL, mul_a/mul_b SHALL be driven combinationally from the latched operands: step0 A[1:0],B[1:0]; step1 A[1:0],B[3:2]; step2 A[3:2],B[1:0]; step3 A[3:2],B[3:2].
REQ-022 In IDLE and DONE, mul_a and mul_b SHALL be 0.
REQ-023 Each MUL cycle SHALL add mul_p, zero-extended to 8 bits and shifted left by 0, 2, 2, 4 for steps 0..3, into the 8-bit accumulator.
REQ-024 Accumulation SHALL be modulo 256; the maximum result 225 never overflows.
REQ-025 After step 3 the FSM SHALL go to DONE, where done=1 for exactly one cycle, then return to IDLE.
REQ-026 Latency: acceptance edge, then 4 MUL cycles, then done in the 5th cycle after the acceptance edge.
REQ-027 Throughput SHALL be one operation per 6 cycles (IDLE, 4 MUL, DONE).
REQ-028 product and id SHALL update only on entry to DONE and hold their values until the next DONE.
REQ-029 Operand or req changes after the acceptance edge SHALL NOT affect the operation in flight.
REQ-030 A request that arrives while busy SHALL wait; it is not lost provided req is held.
REQ-031 busy SHALL be high in MUL and DONE and low in IDLE.

Reset
REQ-032 rst high SHALL force immediately: state IDLE, step 0, accumulator 0, product 0, id 0, done 0, gnt0/gnt1 0, busy 0, last-served pointer = 1 (req0 wins the first tie).
REQ-033 Reset asserted mid-operation SHALL abort the operation with no done pulse; pending requests are re-arbitrated after reset release.

Verification
REQ-034 req0 with a0=15, b0=15 -> gnt0 in cycle 1; done in cycle 5 with product=225 (0xE1), id=0; busy low in cycle 6.
REQ-035 First tie after reset, req0 (3x3) and req1 (10x5) both held -> first done product=9, id=0; second done product=50, id=1; second acceptance in the IDLE cycle after the first DONE.
REQ-036 Repeated ties -> grants alternate 0,1,0,1 and no requester is starved.
REQ-037 a1=0, b1=13 -> product=0; mul_a/mul_b sequence (0,1),(0,3),(0,1),(0,3) observed across the 4 MUL steps.
REQ-038 rst pulsed in MUL step 2 -> all outputs 0 immediately, no done; the held request is re-accepted after release and completes correctly.
REQ-039 Exhaustive 256 operand pairs on each requester against a reference model -> every product exact, every done exactly 5 cycles after its acceptance edge.
